// File: rtl/onehot_encoder_pipe.sv
// onehot_encoder_pipe: two-stage one-hot to binary index encoder, valid/ready on both sides.
// Saturating error counter built only when ONEHOT_ENC_ERRCNT_EN is defined.
module onehot_encoder_pipe #(
  parameter int IN_W      = 16,
  parameter int IDX_W     = 5,
  parameter int PRIO_MODE = 0,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_err,
  output logic                 out_multi,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  generate
    if (IN_W < 2 || IN_W > 64) begin : g_bad_in_w
      $error("IN_W must be in 2..64");
    end
    if ((64'(1) << IDX_W) <= 64'(IN_W)) begin : g_bad_idx_w
      $error("IDX_W too narrow for IN_W and the none code");
    end
  endgenerate

  localparam logic [IDX_W-1:0] NONE = IDX_W'(IN_W);

  logic            s1_valid;
  logic [IN_W-1:0] s1_data;
  logic            s1_zero;
  logic            s1_multi;
  logic            s1_adv;
  logic            s2_adv;
  logic            in_zero;
  logic            in_multi;
  logic [IDX_W-1:0] low_idx;
  logic [IDX_W-1:0] nxt_idx;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // x & (x-1) clears the lowest set bit; anything left means two or more
  assign in_zero  = (in_data == '0);
  assign in_multi = |(in_data & (in_data - IN_W'(1)));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_zero  <= 1'b0;
      s1_multi <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data  <= in_data;
        s1_zero  <= in_zero;
        s1_multi <= in_multi;
      end
    end
  end

  always_comb begin
    low_idx = '0;
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (s1_data[i]) low_idx = IDX_W'(i);
    end
  end

  always_comb begin
    nxt_idx = low_idx;
    if (s1_zero) nxt_idx = NONE;
    else if (s1_multi && PRIO_MODE == 0) nxt_idx = NONE;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_err   <= 1'b0;
      out_multi <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_idx   <= nxt_idx;
        out_err   <= s1_zero || s1_multi;
        out_multi <= s1_multi;
      end
    end
  end

`ifdef ONEHOT_ENC_ERRCNT_EN
  logic [ERR_CNT_W-1:0] cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (err_clr) begin
      cnt <= '0;
    end else if (out_valid && out_ready && out_err && cnt != '1) begin
      cnt <= cnt + ERR_CNT_W'(1);
    end
  end

  assign err_cnt = cnt;
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// tb_onehot_encoder_pipe: randomized and directed checks of onehot_encoder_pipe
// against a queue-based transaction model, strict and lowest-bit policies side by side.
module tb_onehot_encoder_pipe;

  localparam int IN_W  = 16;
  localparam int IDX_W = 5;

  typedef struct {
    logic [IDX_W-1:0] idx0;
    logic [IDX_W-1:0] idx1;
    logic             err;
    logic             multi;
    int               t;
  } exp_t;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic             out_ready = 1'b1;
  logic             err_clr = 1'b0;

  logic             in_ready0, out_valid0, out_err0, out_multi0;
  logic [IDX_W-1:0] out_idx0;
  logic [1:0]       err_cnt0;
  logic             in_ready1, out_valid1, out_err1, out_multi1;
  logic [IDX_W-1:0] out_idx1;
  logic [7:0]       err_cnt1;

  onehot_encoder_pipe #(
    .IN_W(IN_W), .IDX_W(IDX_W), .PRIO_MODE(0), .ERR_CNT_W(2)
  ) dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_idx(out_idx0), .out_err(out_err0), .out_multi(out_multi0),
    .err_clr(err_clr), .err_cnt(err_cnt0)
  );

  onehot_encoder_pipe #(
    .IN_W(IN_W), .IDX_W(IDX_W), .PRIO_MODE(1), .ERR_CNT_W(8)
  ) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_idx(out_idx1), .out_err(out_err1), .out_multi(out_multi1),
    .err_clr(err_clr), .err_cnt(err_cnt1)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int passed = 0;
  int edge_n = 0;
  exp_t q[$];
  int seen0[$];
  int seen1[$];
  int seen_t[$];
  logic [1:0] cnt0 = '0;
  logic [7:0] cnt1 = '0;

  function automatic exp_t model(input logic [IN_W-1:0] d);
    exp_t m;
    int n;
    int low;
    n = $countones(d);
    low = IN_W;
    for (int i = IN_W - 1; i >= 0; i--) if (d[i]) low = i;
    m.err   = (n != 1);
    m.multi = (n >= 2);
    m.idx0  = IDX_W'((n == 1) ? low : IN_W);
    m.idx1  = IDX_W'((n == 0) ? IN_W : low);
    m.t     = 0;
    return m;
  endfunction

  task automatic cycle();
    exp_t f;
    bit ov, rdy, ixf, oxf;
    @(negedge sys_clk);
    ov  = q.size() > 0 && edge_n >= q[0].t + 1;
    rdy = !(q.size() >= 2 && !out_ready);
    checks++;
    if (out_valid0 !== ov || out_valid1 !== ov)
      $display("FAIL out_valid: got %b/%b want %b", out_valid0, out_valid1, ov);
    else passed++;
    checks++;
    if (in_ready0 !== rdy || in_ready1 !== rdy)
      $display("FAIL in_ready: got %b/%b want %b", in_ready0, in_ready1, rdy);
    else passed++;
    if (ov) begin
      f = q[0];
      checks++;
      if (out_idx0 !== f.idx0 || out_err0 !== f.err || out_multi0 !== f.multi)
        $display("FAIL enc_strict: got idx=%0d err=%b multi=%b want idx=%0d err=%b multi=%b",
                 out_idx0, out_err0, out_multi0, f.idx0, f.err, f.multi);
      else passed++;
      checks++;
      if (out_idx1 !== f.idx1 || out_err1 !== f.err || out_multi1 !== f.multi)
        $display("FAIL enc_prio: got idx=%0d err=%b multi=%b want idx=%0d err=%b multi=%b",
                 out_idx1, out_err1, out_multi1, f.idx1, f.err, f.multi);
      else passed++;
    end
    checks++;
    if (err_cnt0 !== cnt0 || err_cnt1 !== cnt1)
      $display("FAIL err_cnt: got %0d/%0d want %0d/%0d", err_cnt0, err_cnt1, cnt0, cnt1);
    else passed++;
    ixf = in_valid && rdy;
    oxf = ov && out_ready;
    @(posedge sys_clk);
    edge_n++;
`ifdef ONEHOT_ENC_ERRCNT_EN
    if (err_clr) begin
      cnt0 = '0;
      cnt1 = '0;
    end else if (oxf && q[0].err) begin
      if (cnt0 != 2'b11) cnt0 = cnt0 + 2'd1;
      if (cnt1 != 8'hFF) cnt1 = cnt1 + 8'd1;
    end
`endif
    if (oxf) begin
      seen0.push_back(int'(q[0].idx0));
      seen1.push_back(int'(q[0].idx1));
      seen_t.push_back(edge_n);
      void'(q.pop_front());
    end
    if (ixf) begin
      f = model(in_data);
      f.t = edge_n;
      q.push_back(f);
    end
    #1;
  endtask

  task automatic drain(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) cycle();
  endtask

  task automatic clear_seen();
    seen0.delete();
    seen1.delete();
    seen_t.delete();
  endtask

  task automatic send(input logic [IN_W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    cycle();
  endtask

  task automatic test_reset();
    #2 sys_rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    checks++;
    if ({out_valid0, out_idx0, out_err0, out_multi0, err_cnt0} !== '0 ||
        {out_valid1, out_idx1, out_err1, out_multi1, err_cnt1} !== '0)
      $display("FAIL reset_outputs: got %b %0d / %b %0d want 0",
               out_valid0, out_idx0, out_valid1, out_idx1);
    else passed++;
    checks++;
    if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1)
      $display("FAIL reset_in_ready: got %b/%b want 1", in_ready0, in_ready1);
    else passed++;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    edge_n++;
  endtask

  task automatic test_onehot_stream();
    clear_seen();
    send(16'h0001);
    send(16'h0080);
    send(16'h8000);
    drain(4);
    checks++;
    if (seen0.size() != 3 || seen_t.size() != 3)
      $display("FAIL stream_count: got %0d want 3", seen0.size());
    else if (seen0[0] != 0 || seen0[1] != 7 || seen0[2] != 15 || seen_t[2] - seen_t[0] != 2)
      $display("FAIL stream_order: got %0d,%0d,%0d want 0,7,15 back-to-back",
               seen0[0], seen0[1], seen0[2]);
    else passed++;
  endtask

  task automatic test_zero();
    clear_seen();
    send(16'h0000);
    drain(3);
    checks++;
    if (seen0.size() != 1 || seen0[0] != IN_W || seen1[0] != IN_W)
      $display("FAIL zero_idx: got n=%0d want idx %0d", seen0.size(), IN_W);
    else passed++;
  endtask

  task automatic test_multi();
    clear_seen();
    send(16'h0120);
    drain(3);
    checks++;
    if (seen0.size() != 1 || seen0[0] != IN_W || seen1[0] != 5)
      $display("FAIL multi_idx: got n=%0d want strict 16 prio 5", seen0.size());
    else passed++;
  endtask

  task automatic test_back_pressure();
    clear_seen();
    out_ready = 1'b0;
    send(16'h0002);
    send(16'h0004);
    in_data = 16'h0008;
    repeat (3) cycle();
    checks++;
    if (out_valid0 !== 1'b1 || out_idx0 !== 5'd1 || in_ready0 !== 1'b0)
      $display("FAIL stall_hold: got v=%b idx=%0d rdy=%b want v=1 idx=1 rdy=0",
               out_valid0, out_idx0, in_ready0);
    else passed++;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    drain(4);
    checks++;
    if (seen0.size() != 3)
      $display("FAIL bp_count: got %0d want 3", seen0.size());
    else if (seen0[0] != 1 || seen0[1] != 2 || seen0[2] != 3 || seen_t[2] - seen_t[0] != 2)
      $display("FAIL bp_order: got %0d,%0d,%0d want 1,2,3 back-to-back",
               seen0[0], seen0[1], seen0[2]);
    else passed++;
  endtask

  task automatic test_err_sat();
    logic [1:0] want;
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    repeat (5) send(16'h0000);
    drain(4);
`ifdef ONEHOT_ENC_ERRCNT_EN
    want = 2'd3;
`else
    want = 2'd0;
`endif
    checks++;
    if (err_cnt0 !== want)
      $display("FAIL err_saturate: got %0d want %0d", err_cnt0, want);
    else passed++;
    send(16'h0000);
    in_valid = 1'b0;
    cycle();
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    checks++;
    if (err_cnt0 !== 2'd0 || err_cnt1 !== 8'd0)
      $display("FAIL err_clr_wins: got %0d/%0d want 0", err_cnt0, err_cnt1);
    else passed++;
    drain(2);
  endtask

  task automatic test_random();
    logic [IN_W-1:0] d;
    int a, b;
    for (int n = 0; n < 400; n++) begin
      a = $urandom_range(0, IN_W - 1);
      b = (a + 1 + $urandom_range(0, IN_W - 2)) % IN_W;
      case ($urandom_range(0, 3))
        0: d = '0;
        1, 2: d = IN_W'(1) << a;
        default: d = IN_W'($urandom) | (IN_W'(1) << a) | (IN_W'(1) << b);
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = d;
      out_ready = ($urandom_range(0, 2) != 0);
      err_clr   = ($urandom_range(0, 19) == 0);
      cycle();
    end
    err_clr = 1'b0;
    drain(4);
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    send(16'h0100);
    send(16'h0200);
    in_valid = 1'b0;
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid0 !== 1'b0 || out_idx0 !== '0 || err_cnt0 !== '0 ||
        out_valid1 !== 1'b0 || out_idx1 !== '0 || err_cnt1 !== '0)
      $display("FAIL async_reset: got v=%b idx=%0d cnt=%0d want 0",
               out_valid0, out_idx0, err_cnt0);
    else passed++;
    checks++;
    if (in_ready0 !== 1'b1)
      $display("FAIL async_reset_ready: got %b want 1", in_ready0);
    else passed++;
    q.delete();
    cnt0 = '0;
    cnt1 = '0;
    #1 sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    edge_n++;
    clear_seen();
    out_ready = 1'b1;
    send(16'h0010);
    drain(4);
    checks++;
    if (seen0.size() != 1 || seen0[0] != 4)
      $display("FAIL post_reset_first: got n=%0d want single idx 4", seen0.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_onehot_stream();
    test_zero();
    test_multi();
    test_back_pressure();
    test_err_sat();
    test_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
